// File: rtl/i2c_bus_bridge.sv
// I2C slave that bridges register reads/writes from the I2C bus onto a simple strobed register bus.
// Define I2C_AUTOINC_EN to honour the CTRL byte's auto-increment flag; otherwise the pointer moves only on CTRL.
module i2c_bus_bridge #(
  parameter logic [6:0] SLAVE_ADDR = 7'h62,
  parameter int         NUM_REGS   = 13,
  parameter int         ADDR_BITS  = 4,
  parameter int         DATA_BITS  = 8
) (
  input  logic                 clk_400K,
  input  logic                 reset,
  input  logic                 scl,
  input  logic                 sda_in,
  output logic                 sda_pull,
  output logic [ADDR_BITS-1:0] bus_addr,
  output logic [DATA_BITS-1:0] bus_wdata,
  input  logic [DATA_BITS-1:0] bus_rdata,
  output logic                 bus_w_en,
  output logic                 bus_r_en
);

  localparam logic [ADDR_BITS-1:0] LAST_PTR   = ADDR_BITS'(NUM_REGS - 1);
  localparam logic [ADDR_BITS:0]   NUM_REGS_W = (ADDR_BITS + 1)'(NUM_REGS);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, CTRL, CTRL_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
  } state_t;

  logic scl_meta_reg, scl_sync_reg, scl_prev_reg;
  logic sda_meta_reg, sda_sync_reg, sda_prev_reg;
  logic [1:0] settle_reg;

  state_t                 state_reg, state_next;
  logic [3:0]             cnt_reg, cnt_next;
  logic [7:0]             shift_reg, shift_next;
  logic [ADDR_BITS-1:0]   ptr_reg, ptr_next;
  logic                   pull_reg, pull_next;
  logic [ADDR_BITS-1:0]   addr_reg, addr_next;
  logic [DATA_BITS-1:0]   wdata_reg, wdata_next;
  logic                   w_en_reg, w_en_next;
  logic                   r_en_reg, r_en_next;
  logic [1:0]             wr_stage_reg, wr_stage_next;
  logic                   rd_stage_reg, rd_stage_next;
`ifdef I2C_AUTOINC_EN
  logic                   ai_reg, ai_next;
`endif

  logic edges_ok, scl_rise, scl_fall, start_det, stop_det, byte_done;
  logic [7:0] shift_in;

  // Synchronizers plus one extra stage for edge detection; edges are ignored until the chain has refilled after reset.
  always_ff @(posedge clk_400K) begin
    if (reset) begin
      scl_meta_reg <= 1'b1;
      scl_sync_reg <= 1'b1;
      scl_prev_reg <= 1'b1;
      sda_meta_reg <= 1'b1;
      sda_sync_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
      settle_reg   <= 2'd0;
    end else begin
      scl_meta_reg <= scl;
      scl_sync_reg <= scl_meta_reg;
      scl_prev_reg <= scl_sync_reg;
      sda_meta_reg <= sda_in;
      sda_sync_reg <= sda_meta_reg;
      sda_prev_reg <= sda_sync_reg;
      if (settle_reg != 2'd3) settle_reg <= settle_reg + 2'd1;
    end
  end

  always_ff @(posedge clk_400K) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      shift_reg    <= '0;
      ptr_reg      <= '0;
      pull_reg     <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      w_en_reg     <= 1'b0;
      r_en_reg     <= 1'b0;
      wr_stage_reg <= '0;
      rd_stage_reg <= 1'b0;
`ifdef I2C_AUTOINC_EN
      ai_reg       <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      shift_reg    <= shift_next;
      ptr_reg      <= ptr_next;
      pull_reg     <= pull_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      w_en_reg     <= w_en_next;
      r_en_reg     <= r_en_next;
      wr_stage_reg <= wr_stage_next;
      rd_stage_reg <= rd_stage_next;
`ifdef I2C_AUTOINC_EN
      ai_reg       <= ai_next;
`endif
    end
  end

  always_comb begin
    edges_ok  = (settle_reg == 2'd3);
    scl_rise  = edges_ok & scl_sync_reg & ~scl_prev_reg;
    scl_fall  = edges_ok & ~scl_sync_reg & scl_prev_reg;
    start_det = edges_ok & scl_sync_reg & scl_prev_reg & sda_prev_reg & ~sda_sync_reg;
    stop_det  = edges_ok & scl_sync_reg & scl_prev_reg & ~sda_prev_reg & sda_sync_reg;
    shift_in  = {shift_reg[6:0], sda_sync_reg};
    byte_done = scl_rise && (cnt_reg == 4'd7);

    state_next    = state_reg;
    cnt_next      = cnt_reg;
    shift_next    = shift_reg;
    ptr_next      = ptr_reg;
    pull_next     = pull_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    w_en_next     = 1'b0;
    r_en_next     = 1'b0;
    wr_stage_next = {wr_stage_reg[0], 1'b0};
    rd_stage_next = 1'b0;
`ifdef I2C_AUTOINC_EN
    ai_next       = ai_reg;
`endif

    // Write path: present address/data one cycle, strobe the next, then hold.
    if (wr_stage_reg[0]) begin
      addr_next  = ptr_reg;
      wdata_next = DATA_BITS'(shift_reg);
    end
    if (wr_stage_reg[1]) w_en_next = 1'b1;
    if (rd_stage_reg)    r_en_next = 1'b1;
    if (r_en_reg)        shift_next = 8'(bus_rdata);
`ifdef I2C_AUTOINC_EN
    if ((w_en_reg || r_en_reg) && ai_reg)
      ptr_next = (ptr_reg == LAST_PTR) ? '0 : ptr_reg + ADDR_BITS'(1);
`endif

    case (state_reg)
      IDLE: ;
      ADDR, CTRL, WDATA: begin
        if (scl_fall) pull_next = 1'b0;
        if (scl_rise) begin
          shift_next = shift_in;
          cnt_next   = cnt_reg + 4'd1;
        end
        if (byte_done) begin
          cnt_next = '0;
          if (state_reg == ADDR) begin
            state_next = (shift_in[7:1] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
          end else if (state_reg == CTRL) begin
            if ({1'b0, shift_in[ADDR_BITS-1:0]} >= NUM_REGS_W) begin
              state_next = WAIT_STOP;
            end else begin
              state_next = CTRL_ACK;
              ptr_next   = shift_in[ADDR_BITS-1:0];
`ifdef I2C_AUTOINC_EN
              ai_next    = shift_in[7];
`endif
            end
          end else begin
            state_next    = WDATA_ACK;
            wr_stage_next = {wr_stage_reg[0], 1'b1};
          end
        end
      end
      ADDR_ACK, CTRL_ACK, WDATA_ACK: begin
        // ACK is driven from the falling edge; the master samples it on the following rise.
        if (scl_fall) pull_next = 1'b1;
        if (scl_rise) begin
          cnt_next = '0;
          if (state_reg == ADDR_ACK && shift_reg[0]) begin
            state_next    = RDATA;
            addr_next     = ptr_reg;
            rd_stage_next = 1'b1;
          end else if (state_reg == ADDR_ACK) begin
            state_next = CTRL;
          end else begin
            state_next = WDATA;
          end
        end
      end
      RDATA: begin
        if (scl_fall) pull_next = ~shift_reg[7];
        if (scl_rise) begin
          shift_next = shift_in;
          cnt_next   = cnt_reg + 4'd1;
        end
        if (byte_done) begin
          cnt_next   = '0;
          state_next = RACK;
        end
      end
      RACK: begin
        if (scl_fall) pull_next = 1'b0;
        if (scl_rise) begin
          if (!sda_sync_reg) begin
            state_next    = RDATA;
            addr_next     = ptr_reg;
            rd_stage_next = 1'b1;
          end else begin
            state_next = WAIT_STOP;
          end
        end
      end
      WAIT_STOP: begin
        if (scl_fall) pull_next = 1'b0;
      end
      default: state_next = IDLE;
    endcase

    // Bus conditions win over everything, including bus cycles not yet issued.
    if (stop_det || start_det) begin
      state_next    = stop_det ? IDLE : ADDR;
      cnt_next      = '0;
      pull_next     = 1'b0;
      wr_stage_next = '0;
      rd_stage_next = 1'b0;
      w_en_next     = 1'b0;
      r_en_next     = 1'b0;
    end
  end

  assign sda_pull  = pull_reg;
  assign bus_addr  = addr_reg;
  assign bus_wdata = wdata_reg;
  assign bus_w_en  = w_en_reg;
  assign bus_r_en  = r_en_reg;

endmodule

// File: tb/tb_i2c_bus_bridge.sv
// Randomized I2C master driving i2c_bus_bridge, with a register-map reference model and a bus-strobe scoreboard.
`timescale 1ns/1ps
module tb_i2c_bus_bridge;
  localparam int NUM_REGS = 13;
  localparam int QTR = 5;
`ifdef I2C_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef struct {
    bit         is_wr;
    logic [3:0] addr;
    logic [7:0] data;
  } bus_ev_t;

  logic clk_400K = 1'b0;
  logic reset = 1'b1;
  logic scl = 1'b1;
  logic master_sda = 1'b1;
  logic sda_in, sda_pull;
  logic [3:0] bus_addr;
  logic [7:0] bus_wdata, bus_rdata;
  logic bus_w_en, bus_r_en;

  logic [7:0] dev_mem [0:15];
  logic [7:0] ref_mem [0:15];
  logic [7:0] tx_buf [0:7];
  int ref_ptr;
  bit ref_ai;
  bus_ev_t exp_q[$];
  int checks = 0;
  int failures = 0;
  logic prev_w_en = 1'b0;
  logic [3:0] prev_addr = '0;
  logic [7:0] prev_wdata = '0;

  assign sda_in = master_sda & ~sda_pull;
  assign bus_rdata = dev_mem[bus_addr];

  i2c_bus_bridge dut (
    .clk_400K (clk_400K),
    .reset    (reset),
    .scl      (scl),
    .sda_in   (sda_in),
    .sda_pull (sda_pull),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_w_en (bus_w_en),
    .bus_r_en (bus_r_en)
  );

  always #1250 clk_400K = ~clk_400K;

  always @(posedge clk_400K) if (bus_w_en) dev_mem[bus_addr] <= bus_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_advance();
    if (AUTOINC && ref_ai) ref_ptr = (ref_ptr == NUM_REGS - 1) ? 0 : ref_ptr + 1;
  endfunction

  // Scoreboard: every strobe must match the oldest expected bus event.
  always @(negedge clk_400K) begin
    bus_ev_t ev;
    if (!reset) begin
      if (bus_w_en || bus_r_en) begin
        check("strobe_exclusive", 32'(bus_w_en & bus_r_en), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe actual w=%0b r=%0b addr=%0h expected no strobe", bus_w_en, bus_r_en, bus_addr);
        end else begin
          ev = exp_q.pop_front();
          check("strobe_kind", 32'(bus_w_en), 32'(ev.is_wr));
          check("strobe_addr", 32'(bus_addr), 32'(ev.addr));
          if (ev.is_wr) check("strobe_wdata", 32'(bus_wdata), 32'(ev.data));
        end
      end
      if (bus_w_en) begin
        check("w_en_width", 32'(prev_w_en), 32'd0);
        check("addr_setup", 32'(prev_addr), 32'(bus_addr));
        check("wdata_setup", 32'(prev_wdata), 32'(bus_wdata));
      end
      if (prev_w_en) begin
        check("addr_hold", 32'(bus_addr), 32'(prev_addr));
        check("wdata_hold", 32'(bus_wdata), 32'(prev_wdata));
      end
    end
    prev_w_en  = bus_w_en;
    prev_addr  = bus_addr;
    prev_wdata = bus_wdata;
  end

  task automatic q();
    repeat (QTR) @(negedge clk_400K);
  endtask

  task automatic i2c_start();
    master_sda = 1'b1; q();
    scl = 1'b1; q();
    master_sda = 1'b0; q();
    scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    master_sda = 1'b0; q();
    scl = 1'b1; q();
    master_sda = 1'b1; q(); q();
  endtask

  task automatic i2c_bit(input logic b, output logic line);
    master_sda = b; q();
    scl = 1'b1; q();
    line = sda_in; q();
    scl = 1'b0; q();
  endtask

  task automatic i2c_write(input logic [7:0] b, output logic ack);
    logic l;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], l);
    i2c_bit(1'b1, l);
    ack = ~l;
  endtask

  task automatic i2c_read(input logic mack, output logic [7:0] b);
    logic l;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, l);
      b[i] = l;
    end
    i2c_bit(~mack, l);
  endtask

  task automatic do_write(input logic [7:0] ctrl, input int n, input bit keep_open);
    logic ack;
    bit ctrl_ok;
    ctrl_ok = (int'(ctrl[3:0]) < NUM_REGS);
    $display("tx write ctrl=%02h bytes=%0d", ctrl, n);
    i2c_start();
    i2c_write(8'hC4, ack);
    check("addr_ack_w", 32'(ack), 32'd1);
    i2c_write(ctrl, ack);
    check("ctrl_ack", 32'(ack), 32'(ctrl_ok));
    if (!ctrl_ok) begin
      i2c_stop();
      return;
    end
    ref_ptr = int'(ctrl[3:0]);
    ref_ai  = ctrl[7];
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{1'b1, 4'(ref_ptr), tx_buf[i]});
      ref_mem[ref_ptr] = tx_buf[i];
      ref_advance();
      i2c_write(tx_buf[i], ack);
      check("data_ack", 32'(ack), 32'd1);
    end
    if (!keep_open) i2c_stop();
  endtask

  task automatic do_read(input logic [7:0] ctrl, input int n);
    logic ack;
    logic [7:0] b;
    logic [7:0] exp_b [0:7];
    do_write(ctrl, 0, 1'b1);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{1'b0, 4'(ref_ptr), 8'h00});
      exp_b[i] = ref_mem[ref_ptr];
      ref_advance();
    end
    $display("tx read ptr=%0d bytes=%0d", ctrl[3:0], n);
    i2c_start();
    i2c_write(8'hC5, ack);
    check("addr_ack_r", 32'(ack), 32'd1);
    for (int i = 0; i < n; i++) begin
      i2c_read(i < n - 1, b);
      check("read_byte", 32'(b), 32'(exp_b[i]));
    end
    i2c_stop();
  endtask

  task automatic wrong_addr();
    logic ack;
    $display("tx wrong address 0xC6");
    i2c_start();
    i2c_write(8'hC6, ack);
    check("wrong_addr_nack", 32'(ack), 32'd0);
    i2c_write(8'h55, ack);
    check("wait_stop_nack", 32'(ack), 32'd0);
    i2c_stop();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sda_pull"}, 32'(sda_pull), 32'd0);
    check({tag, "_w_en"}, 32'(bus_w_en), 32'd0);
    check({tag, "_r_en"}, 32'(bus_r_en), 32'd0);
    check({tag, "_addr"}, 32'(bus_addr), 32'd0);
    check({tag, "_wdata"}, 32'(bus_wdata), 32'd0);
  endtask

  initial begin
    logic ack, l;
    logic [7:0] ctrl;
    logic [7:0] partial;
    int n;
    for (int i = 0; i < 16; i++) begin
      dev_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    ref_ptr = 0;
    ref_ai  = 1'b0;
    repeat (3) @(negedge clk_400K);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (6) @(negedge clk_400K);

    tx_buf[0] = 8'h40;
    do_write(8'h82, 1, 1'b0);
    tx_buf[0] = 8'h40; tx_buf[1] = 8'h80; tx_buf[2] = 8'hC0;
    do_write(8'h82, 3, 1'b0);
    tx_buf[0] = 8'h5A; tx_buf[1] = 8'hA5;
    do_write(8'h8C, 2, 1'b0);
    wrong_addr();
    tx_buf[0] = 8'h11;
    do_write(8'h02, 1, 1'b0);
    tx_buf[0] = 8'h22;
    do_write(8'h03, 1, 1'b0);
    do_read(8'h82, 2);
    tx_buf[0] = 8'h00;
    do_write(8'h0E, 1, 1'b0);

    // START in the middle of a data byte: the partial byte must never reach the bus.
    $display("tx aborted byte then restart");
    i2c_start();
    i2c_write(8'hC4, ack);
    check("abort_addr_ack", 32'(ack), 32'd1);
    i2c_write(8'h05, ack);
    check("abort_ctrl_ack", 32'(ack), 32'd1);
    partial = 8'hA5;
    for (int i = 7; i >= 4; i--) i2c_bit(partial[i], l);
    tx_buf[0] = 8'h3C;
    do_write(8'h07, 1, 1'b0);

    for (int t = 0; t < 16; t++) begin
      n = int'($urandom_range(1, 3));
      for (int i = 0; i < 8; i++) tx_buf[i] = 8'($urandom);
      case ($urandom_range(0, 3))
        0, 1: begin
          ctrl = 8'($urandom);
          do_write(ctrl, n, 1'b0);
        end
        2: begin
          ctrl = 8'($urandom);
          ctrl[3:0] = 4'($urandom_range(0, NUM_REGS - 1));
          do_read(ctrl, n);
        end
        default: wrong_addr();
      endcase
    end

    // Reset while SCL is high during the 4th data bit of a write.
    $display("tx reset during data bit 4");
    i2c_start();
    i2c_write(8'hC4, ack);
    check("rst_addr_ack", 32'(ack), 32'd1);
    i2c_write(8'h83, ack);
    check("rst_ctrl_ack", 32'(ack), 32'd1);
    partial = 8'hA5;
    for (int i = 7; i >= 5; i--) i2c_bit(partial[i], l);
    master_sda = partial[4]; q();
    scl = 1'b1; q();
    reset = 1'b1;
    @(negedge clk_400K);
    check_reset_outputs("midrst");
    reset = 1'b0;
    ref_ptr = 0;
    ref_ai  = 1'b0;
    q();
    scl = 1'b0; q();
    for (int i = 3; i >= 0; i--) i2c_bit(partial[i], l);
    i2c_bit(1'b1, l);
    check("post_reset_nack", 32'(l), 32'd1);
    i2c_stop();

    tx_buf[0] = 8'h77;
    do_write(8'h0A, 1, 1'b0);
    do_read(8'h0A, 1);

    repeat (50) @(negedge clk_400K);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
